// File: rtl/pio_pkg.sv
// Shared constants for the button/switch input PIO: register addresses and edge-capture modes.
package pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_RSVD    = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/button_pio_in_if.sv
// Avalon-MM slave bus bundle for the input PIO (fixed read latency 1, no waitrequest).
interface button_pio_in_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       address;
  logic             chipselect;
  logic             read_n;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_debounce.sv
// One-bit debouncer: dout follows din only after din has differed from dout
// for DEBOUNCE_CYCLES consecutive clocks.
module pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_VAL        = 1'b1
)(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Any return to agreement restarts the count, so short glitches never propagate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= IDLE_VAL;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/button_pio_in.sv
// Input PIO: synchronise pins, optional per-bit debounce (PIO_DEBOUNCE_EN),
// per-bit edge capture with write-1-to-clear and a masked level IRQ.
module button_pio_in
  import pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               EDGE_TYPE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}},
  parameter int               DEBOUNCE_CYCLES = 50000
)(
  input  logic             clk,
  input  logic             reset_n,
  button_pio_in_if.slave   bus,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);
  logic [WIDTH-1:0] sync1, sync2, stable, prev;
  logic [WIDTH-1:0] cap, mask;
  logic [WIDTH-1:0] rise, fall, edge_sel, clr, rd_mux;
  logic             rd, wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_VAL        (IDLE_LEVEL[i])
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync2[i]),
      .dout    (stable[i])
    );
  end
`else
  assign stable = sync2;
`endif

  assign rise     = stable & ~prev;
  assign fall     = ~stable & prev;
  assign edge_sel = (EDGE_TYPE == EDGE_ANY)  ? (rise | fall) :
                    (EDGE_TYPE == EDGE_FALL) ? fall : rise;

  assign rd  = bus.chipselect & ~bus.read_n;
  assign wr  = bus.chipselect & ~bus.write_n;
  assign clr = (wr && pio_addr_e'(bus.address) == PIO_ADDR_EDGECAP) ? bus.writedata : '0;

  always_comb begin
    rd_mux = '0;
    case (pio_addr_e'(bus.address))
      PIO_ADDR_DATA:    rd_mux = stable;
      PIO_ADDR_IRQMASK: rd_mux = mask;
      PIO_ADDR_EDGECAP: rd_mux = cap;
      default:          rd_mux = '0;
    endcase
  end

  // Set beats clear so an edge coinciding with its own clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= IDLE_LEVEL;
      cap          <= '0;
      mask         <= '0;
      bus.readdata <= '0;
    end else begin
      prev <= stable;
      cap  <= (cap & ~clr) | edge_sel;
      if (wr && pio_addr_e'(bus.address) == PIO_ADDR_IRQMASK) mask <= bus.writedata;
      if (rd) bus.readdata <= rd_mux;
    end
  end

  assign irq = |(cap & mask);
endmodule

// File: tb/tb_button_pio_in.sv
// Bench: falling-edge and any-edge instances driven in lockstep, checked against a cycle reference model.
module tb_button_pio_in;
  localparam int W     = 4;
  localparam int DB    = 8;
`ifdef PIO_DEBOUNCE_EN
  localparam int SETTLE = 4 + DB;
`else
  localparam int SETTLE = 4;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         cs, rd_n, wr_n;
  logic [W-1:0] wdata, pins;
  logic         irq_f, irq_a;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  button_pio_in_if #(.WIDTH(W)) bus_f ();
  button_pio_in_if #(.WIDTH(W)) bus_a ();

  assign bus_f.address = address;  assign bus_a.address = address;
  assign bus_f.chipselect = cs;    assign bus_a.chipselect = cs;
  assign bus_f.read_n = rd_n;      assign bus_a.read_n = rd_n;
  assign bus_f.write_n = wr_n;     assign bus_a.write_n = wr_n;
  assign bus_f.writedata = wdata;  assign bus_a.writedata = wdata;

  button_pio_in #(.WIDTH(W), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF), .DEBOUNCE_CYCLES(DB)) dut_f (
    .clk(clk), .reset_n(reset_n), .bus(bus_f), .irq(irq_f), .in_port(pins));
  button_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF), .DEBOUNCE_CYCLES(DB)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .irq(irq_a), .in_port(pins));

  // Reference model: pins pass a 2-deep delay line, then (optionally) a run-length filter.
  logic [W-1:0] m_s1, m_s2, m_stab, m_prev, m_cap_f, m_cap_a, m_mask, m_rd_f, m_rd_a;
  logic [W-1:0] m_rise, m_fall, m_clr, m_nst;
  int           m_run [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stab = 4'hF; m_prev = 4'hF;
      m_cap_f = '0; m_cap_a = '0; m_mask = '0; m_rd_f = '0; m_rd_a = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_rise = m_stab & ~m_prev;
      m_fall = ~m_stab & m_prev;
      m_clr  = (cs && !wr_n && address == 2'd3) ? wdata : '0;
      if (cs && !rd_n) begin
        case (address)
          2'd0: begin m_rd_f = m_stab;  m_rd_a = m_stab;  end
          2'd2: begin m_rd_f = m_mask;  m_rd_a = m_mask;  end
          2'd3: begin m_rd_f = m_cap_f; m_rd_a = m_cap_a; end
          default: begin m_rd_f = '0; m_rd_a = '0; end
        endcase
      end
      m_cap_f = (m_cap_f & ~m_clr) | m_fall;
      m_cap_a = (m_cap_a & ~m_clr) | m_rise | m_fall;
      if (cs && !wr_n && address == 2'd2) m_mask = wdata;
      m_prev = m_stab;
`ifdef PIO_DEBOUNCE_EN
      m_nst = m_stab;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_nst[i] = m_s2[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
`else
      m_nst = m_s1;
`endif
      m_s2   = m_s1;
      m_s1   = pins;
      m_stab = m_nst;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_rd_f"}, 32'(bus_f.readdata), 32'(m_rd_f));
    chk({tag, "_rd_a"}, 32'(bus_a.readdata), 32'(m_rd_a));
    chk({tag, "_irq_f"}, 32'(irq_f), 32'(|(m_cap_f & m_mask)));
    chk({tag, "_irq_a"}, 32'(irq_a), 32'(|(m_cap_a & m_mask)));
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag);
    address = a; cs = 1'b1; rd_n = 1'b0;
    tick();
    cs = 1'b0; rd_n = 1'b1;
    chk_model(tag);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    address = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
    tick();
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0; pins = 4'hF; address = '0; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; wdata = '0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    bus_read(2'd0, "rst_data"); chk("rst_data_const", 32'(bus_f.readdata), 32'hF);
    bus_read(2'd2, "rst_mask"); chk("rst_mask_const", 32'(bus_f.readdata), 32'h0);
    bus_read(2'd3, "rst_cap");  chk("rst_cap_const", 32'(bus_a.readdata), 32'h0);
    chk("rst_irq_const", 32'(irq_f), 32'h0);

    // Falling edge on bit 0: capture lands on the 3rd edge after the pin change
    pins = 4'hE;
    tick(); tick();
    bus_read(2'd3, "cap_edge3");
`ifndef PIO_DEBOUNCE_EN
    chk("cap_before_3rd_edge", 32'(bus_f.readdata), 32'h0);
`endif
    wait_cycles(SETTLE);
    bus_read(2'd3, "cap_after"); chk("cap_bit0_const", 32'(bus_f.readdata), 32'h1);
    chk("irq_mask0_const", 32'(irq_f), 32'h0);
    bus_write(2'd2, 4'h1);
    chk_model("mask_wr"); chk("irq_after_mask_const", 32'(irq_f), 32'h1);

    // Write-1-to-clear, and set-wins on a coincident edge
    pins = 4'hC; wait_cycles(SETTLE);
    bus_read(2'd3, "cap3"); chk("cap3_const", 32'(bus_f.readdata), 32'h3);
    bus_write(2'd3, 4'h1);
    bus_read(2'd3, "cap_clr1"); chk("cap_clr1_const", 32'(bus_f.readdata), 32'h2);
    pins = 4'hE; wait_cycles(SETTLE);
    bus_write(2'd3, 4'hF);
    pins = 4'hC;
`ifdef PIO_DEBOUNCE_EN
    wait_cycles(DB + 1);
`else
    tick(); tick();
`endif
    bus_write(2'd3, 4'h2);
    bus_read(2'd3, "set_wins"); chk("set_wins_const", 32'(bus_f.readdata), 32'h2);

    // Any-edge: a low pulse on bit 2 sets capture; cleared, then set again
    bus_write(2'd3, 4'hF);
    pins = 4'h8; wait_cycles(5 + (SETTLE - 4));
    pins = 4'hC; wait_cycles(SETTLE);
    bus_read(2'd3, "pulse_cap"); chk("pulse_cap_any_const", 32'(bus_a.readdata), 32'h4);
    bus_write(2'd3, 4'h4);
    bus_read(2'd3, "pulse_clr"); chk("pulse_clr_const", 32'(bus_a.readdata), 32'h0);
    pins = 4'h8; wait_cycles(SETTLE);
    bus_read(2'd3, "pulse_again"); chk("pulse_again_const", 32'(bus_a.readdata), 32'h4);
    pins = 4'hC; wait_cycles(SETTLE);

`ifdef PIO_DEBOUNCE_EN
    // Glitch shorter than the debounce window is filtered; a long one passes
    pins = 4'hF; wait_cycles(SETTLE); bus_write(2'd3, 4'hF); wait_cycles(2);
    pins = 4'hE; wait_cycles(5); pins = 4'hF; wait_cycles(20);
    bus_read(2'd0, "glitch_data"); chk("glitch_data_const", 32'(bus_f.readdata), 32'hF);
    bus_read(2'd3, "glitch_cap");  chk("glitch_cap_const", 32'(bus_f.readdata), 32'h0);
    pins = 4'hE; wait_cycles(20);
    bus_read(2'd0, "long_data"); chk("long_data_const", 32'(bus_f.readdata), 32'hE);
    bus_read(2'd3, "long_cap");  chk("long_cap_const", 32'(bus_f.readdata), 32'h1);
`endif

    // Reset mid-operation with everything captured and irq high
    pins = 4'h0; wait_cycles(SETTLE);
    pins = 4'hF; wait_cycles(SETTLE);
    bus_write(2'd2, 4'hF);
    bus_read(2'd3, "pre_rst_cap"); chk("pre_rst_cap_const", 32'(bus_a.readdata), 32'hF);
    chk("pre_rst_irq_const", 32'(irq_f), 32'h1);
    reset_n = 1'b0; #1;
    chk("rst_irq_async", 32'(irq_f), 32'h0);
    chk("rst_rd_async", 32'(bus_a.readdata), 32'h0);
    tick();
    reset_n = 1'b1;
    bus_read(2'd2, "post_rst_mask"); chk("post_rst_mask_const", 32'(bus_f.readdata), 32'h0);
    wait_cycles(SETTLE);
    bus_read(2'd3, "post_rst_cap"); chk("post_rst_cap_const", 32'(bus_a.readdata), 32'h0);
    bus_read(2'd0, "post_rst_data");

    // Random traffic: pins, reads, writes and simultaneous read+write
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) pins = W'($urandom);
      cs      = 1'($urandom_range(0, 1));
      rd_n    = 1'($urandom_range(0, 1));
      wr_n    = 1'($urandom_range(0, 1));
      address = 2'($urandom);
      wdata   = W'($urandom);
      tick();
      chk_model("rand");
    end
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
